// File: rtl/c2c_link_arbiter.sv
// c2c_link_arbiter: master-side scheduler for the chip-to-chip link.
// Picks one of NREQ local requesters round-robin, latches its data, then
// runs request -> ack -> notice hold -> valid data -> ack release on the
// shared link and reports done/timeout back to the grantee.
module c2c_link_arbiter #(
    parameter int NREQ        = 4,
    parameter int DW          = 3,
    parameter int HOLD_CYC    = 100_000_000,
    parameter int TIMEOUT_CYC = 200_000_000,
    localparam int IW         = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic                 ack,
    output logic                 request2s,
    output logic                 valid,
    output logic [DW-1:0]        data,
    output logic                 notice,
    output logic                 busy,
    output logic [IW-1:0]        gnt_idx,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      timeout
);

    localparam int MAXC = (HOLD_CYC > TIMEOUT_CYC) ? HOLD_CYC : TIMEOUT_CYC;
    localparam int CW   = $clog2(MAXC) + 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_HOLD     = 2'd2,
        S_SEND     = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     gnt_q, gnt_d;
    logic [DW-1:0]     lat_q, lat_d;
    logic              req2s_q, req2s_d;
    logic              valid_q, valid_d;
    logic [DW-1:0]     data_q, data_d;
    logic              notice_q, notice_d;
    logic              busy_q, busy_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [NREQ-1:0]   tmo_q, tmo_d;

    logic              arb_hit;
    logic [IW-1:0]     arb_idx;
    logic [DW-1:0]     arb_data;
    int                arb_k;

    // Pointer advance after a finished or abandoned transfer, wrapping at NREQ-1.
    function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] x);
        return (x == IW'(NREQ - 1)) ? '0 : x + 1'b1;
    endfunction

    // Round-robin pick: first set req bit scanning ptr, ptr+1, ... modulo NREQ.
    always_comb begin
        arb_hit  = 1'b0;
        arb_idx  = '0;
        arb_data = '0;
        arb_k    = 0;
        for (int i = 0; i < NREQ; i++) begin
            arb_k = int'(ptr_q) + i;
            if (arb_k >= NREQ) arb_k = arb_k - NREQ;
            if (!arb_hit && req[IW'(arb_k)]) begin
                arb_hit = 1'b1;
                arb_idx = IW'(arb_k);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == IW'(i)) arb_data = req_data[i*DW +: DW];
        end
    end

    // Next-state and next-output logic for the link handshake.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        lat_d    = lat_q;
        req2s_d  = req2s_q;
        valid_d  = valid_q;
        data_d   = data_q;
        notice_d = notice_q;
        busy_d   = busy_q;
        done_d   = '0;
        tmo_d    = '0;
        case (state_q)
            S_IDLE: begin
                // A high ack here is left over from the last transfer; wait it out.
                if (arb_hit && !ack) begin
                    gnt_d   = arb_idx;
                    lat_d   = arb_data;
                    req2s_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (ack) begin
                    req2s_d  = 1'b0;
                    notice_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_HOLD;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    req2s_d       = 1'b0;
                    tmo_d[gnt_q]  = 1'b1;
                    ptr_d         = inc_mod(gnt_q);
                    busy_d        = 1'b0;
                    cnt_d         = '0;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                // Ack is ignored here; it may already have been released.
                if (cnt_q == CW'(HOLD_CYC - 1)) begin
                    notice_d = 1'b0;
                    data_d   = lat_q;
                    valid_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SEND: begin
                if (!ack) begin
                    valid_d       = 1'b0;
                    data_d        = '0;
                    done_d[gnt_q] = 1'b1;
                    ptr_d         = inc_mod(gnt_q);
                    busy_d        = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                req2s_d  = 1'b0;
                valid_d  = 1'b0;
                data_d   = '0;
                notice_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transfer without a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            gnt_q    <= '0;
            lat_q    <= '0;
            req2s_q  <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            notice_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            lat_q    <= lat_d;
            req2s_q  <= req2s_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            notice_q <= notice_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
        end
    end

    assign request2s = req2s_q;
    assign valid     = valid_q;
    assign data      = data_q;
    assign notice    = notice_q;
    assign busy      = busy_q;
    assign gnt_idx   = gnt_q;
    assign done      = done_q;
    assign timeout   = tmo_q;

endmodule

// File: tb/tb_c2c_link_arbiter.sv
// Directed bench for c2c_link_arbiter with short hold/timeout counts.
module tb_c2c_link_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] req_data;
    logic        ack;
    logic        request2s;
    logic        valid;
    logic [2:0]  data;
    logic        notice;
    logic        busy;
    logic [1:0]  gnt_idx;
    logic [3:0]  done;
    logic [3:0]  timeout;

    int checks = 0;
    int errors = 0;

    c2c_link_arbiter #(
        .NREQ(4), .DW(3), .HOLD_CYC(4), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .request2s(request2s), .valid(valid), .data(data), .notice(notice),
        .busy(busy), .gnt_idx(gnt_idx), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [11:0] rd;
        logic        ack;
        logic [16:0] exp;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t v(input logic r, input logic [3:0] rq, input logic [11:0] rd,
                               input logic ak, input logic e_r2s, input logic e_vld,
                               input logic [2:0] e_dat, input logic e_ntc, input logic e_bsy,
                               input logic [1:0] e_gnt, input logic [3:0] e_dn,
                               input logic [3:0] e_to);
        vec_t t;
        t.rst = r; t.req = rq; t.rd = rd; t.ack = ak;
        t.exp = {e_r2s, e_vld, e_dat, e_ntc, e_bsy, e_gnt, e_dn, e_to};
        return t;
    endfunction

    function automatic logic [16:0] outs();
        return {request2s, valid, data, notice, busy, gnt_idx, done, timeout};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Slave side of one transfer, from the grant up to the cleared done pulse.
    task automatic xfer(input int idx, input logic [2:0] exp_d, input bit drop_in_hold,
                        input logic [11:0] alt_data);
        int n;
        n = 0;
        while (request2s !== 1'b1 && n < 20) begin cyc(); n++; end
        chk("req2s_seen", {31'd0, request2s}, 1);
        chk("gnt_idx", {30'd0, gnt_idx}, idx);
        chk("data_before_send", {29'd0, data}, 0);
        cyc();
        chk("req2s_wait", {31'd0, request2s}, 1);
        ack = 1'b1;
        cyc();
        chk("notice_on", {31'd0, notice}, 1);
        chk("req2s_off", {31'd0, request2s}, 0);
        if (drop_in_hold) begin
            ack = 1'b0;
            req_data = alt_data;
        end
        n = 1;
        while (notice === 1'b1 && n < 20) begin
            cyc();
            if (notice === 1'b1) n++;
        end
        chk("notice_len", n, 4);
        chk("valid_on", {31'd0, valid}, 1);
        chk("send_data", {29'd0, data}, {29'd0, exp_d});
        if (!drop_in_hold) begin
            cyc();
            cyc();
            chk("valid_held", {31'd0, valid}, 1);
            chk("data_held", {29'd0, data}, {29'd0, exp_d});
            ack = 1'b0;
        end
        cyc();
        chk("valid_off", {31'd0, valid}, 0);
        chk("data_off", {29'd0, data}, 0);
        chk("done_pulse", {28'd0, done}, 32'd1 << idx);
        chk("busy_off", {31'd0, busy}, 0);
        cyc();
        chk("done_clear", {28'd0, done}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got stuck want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; req_data = '0; ack = 1'b0;

        // Transfer for requester 0 (slave acks 2 cycles late), then a timeout for 2.
        tbl[0]  = v(1, 4'b0000, 12'h005, 0, 0,0,3'b000,0,0, 2'd0, 4'b0000, 4'b0000);
        tbl[1]  = v(0, 4'b0001, 12'h005, 0, 1,0,3'b000,0,1, 2'd0, 4'b0000, 4'b0000);
        tbl[2]  = v(0, 4'b0000, 12'h000, 0, 1,0,3'b000,0,1, 2'd0, 4'b0000, 4'b0000);
        tbl[3]  = v(0, 4'b0000, 12'h000, 1, 0,0,3'b000,1,1, 2'd0, 4'b0000, 4'b0000);
        tbl[4]  = v(0, 4'b0000, 12'h000, 1, 0,0,3'b000,1,1, 2'd0, 4'b0000, 4'b0000);
        tbl[5]  = v(0, 4'b0000, 12'h000, 1, 0,0,3'b000,1,1, 2'd0, 4'b0000, 4'b0000);
        tbl[6]  = v(0, 4'b0000, 12'h000, 1, 0,0,3'b000,1,1, 2'd0, 4'b0000, 4'b0000);
        tbl[7]  = v(0, 4'b0000, 12'h000, 1, 0,1,3'b101,0,1, 2'd0, 4'b0000, 4'b0000);
        tbl[8]  = v(0, 4'b0000, 12'h000, 1, 0,1,3'b101,0,1, 2'd0, 4'b0000, 4'b0000);
        tbl[9]  = v(0, 4'b0000, 12'h000, 1, 0,1,3'b101,0,1, 2'd0, 4'b0000, 4'b0000);
        tbl[10] = v(0, 4'b0000, 12'h000, 0, 0,0,3'b000,0,0, 2'd0, 4'b0001, 4'b0000);
        tbl[11] = v(0, 4'b0000, 12'h000, 0, 0,0,3'b000,0,0, 2'd0, 4'b0000, 4'b0000);
        tbl[12] = v(0, 4'b0100, 12'h0C0, 0, 1,0,3'b000,0,1, 2'd2, 4'b0000, 4'b0000);
        for (int i = 13; i < 20; i++)
            tbl[i] = v(0, 4'b0000, 12'h0C0, 0, 1,0,3'b000,0,1, 2'd2, 4'b0000, 4'b0000);
        tbl[20] = v(0, 4'b0000, 12'h0C0, 0, 0,0,3'b000,0,0, 2'd2, 4'b0000, 4'b0100);
        tbl[21] = v(0, 4'b1001, 12'h000, 0, 1,0,3'b000,0,1, 2'd3, 4'b0000, 4'b0000);
        tbl[22] = v(1, 4'b0000, 12'h000, 0, 0,0,3'b000,0,0, 2'd0, 4'b0000, 4'b0000);

        for (int i = 0; i < 23; i++) begin
            rst = tbl[i].rst; req = tbl[i].req; req_data = tbl[i].rd; ack = tbl[i].ack;
            cyc();
            checks++;
            if (outs() !== tbl[i].exp) begin
                errors++;
                $display("FAIL vec%0d got %h want %h", i, outs(), tbl[i].exp);
            end
        end

        // All four held high: grants rotate 0,1,2,3,0.
        rst = 1'b1; cyc(); rst = 1'b0;
        req = 4'b1111;
        req_data = {3'b001, 3'b100, 3'b111, 3'b010};
        xfer(0, 3'b010, 0, 12'h000);
        xfer(1, 3'b111, 0, 12'h000);
        xfer(2, 3'b100, 0, 12'h000);
        xfer(3, 3'b001, 0, 12'h000);
        xfer(0, 3'b010, 0, 12'h000);
        req = 4'b0000;

        // Stale ack blocks arbitration until it falls.
        rst = 1'b1; cyc(); rst = 1'b0;
        ack = 1'b1; req = 4'b0010; req_data = 12'h028;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stale_ack_req2s", {31'd0, request2s}, 0);
            chk("stale_ack_busy", {31'd0, busy}, 0);
        end
        ack = 1'b0;
        cyc();
        chk("after_ack_req2s", {31'd0, request2s}, 1);
        req = 4'b0000;
        xfer(1, 3'b101, 0, 12'h000);

        // Data change and ack release during hold.
        rst = 1'b1; cyc(); rst = 1'b0;
        req = 4'b0010; req_data = 12'b000_000_110_000;
        cyc();
        req = 4'b0000;
        xfer(1, 3'b110, 1, 12'b000_000_011_000);

        // Reset in SEND: everything clears, no done, pointer back to 0.
        rst = 1'b1; cyc(); rst = 1'b0;
        req = 4'b0100; req_data = 12'h1C0;
        cyc();
        chk("rst_seq_gnt", {30'd0, gnt_idx}, 2);
        req = 4'b0000; ack = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) cyc();
        chk("rst_seq_valid", {31'd0, valid}, 1);
        rst = 1'b1;
        cyc();
        chk("rst_outputs", {15'd0, outs()}, 0);
        rst = 1'b0; ack = 1'b0;
        cyc();
        chk("rst_no_done", {15'd0, outs()}, 0);
        req = 4'b1111;
        cyc();
        chk("rst_gnt0", {30'd0, gnt_idx}, 0);
        chk("rst_gnt_req2s", {31'd0, request2s}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
